// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy/threshold flags and error pulses; standard read has 1-cycle latency, FWFT shows the head word combinationally.
// Backpressure: writes to a full FIFO are dropped (OVERFLOW) unless a pop frees the slot that cycle; reads from empty are ignored (UNDERFLOW).
module fifo_param #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 8,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         wr,
    input  logic                         rd,
    input  logic [DATA_WIDTH-1:0]        dataIn,
    output logic [DATA_WIDTH-1:0]        dataOut,
    output logic                         EMPTY,
    output logic                         FULL,
    output logic                         ALMOST_EMPTY,
    output logic                         ALMOST_FULL,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         OVERFLOW,
    output logic                         UNDERFLOW
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  push, pop;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts a write.
    always_comb begin
        pop      = en & rd & ~EMPTY;
        push     = en & wr & (~FULL | pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d  = count_q + CW'(push) - CW'(pop);
        ovf_d    = en & wr & FULL & ~pop;
        udf_d    = en & rd & EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= dataIn;
    end

    assign count        = count_q;
    assign EMPTY        = (count_q == '0);
    assign FULL         = (count_q == CW'(DEPTH));
    assign ALMOST_EMPTY = (count_q <= CW'(AEMPTY_THRESH));
    assign ALMOST_FULL  = (count_q >= CW'(AFULL_THRESH));
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = udf_q;

    generate
        if (FWFT != 0) begin : g_fwft
            assign dataOut = mem_q[rd_ptr_q];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (rst)      dout_q <= '0;
                else if (pop) dout_q <= mem_q[rd_ptr_q];
            end
            assign dataOut = dout_q;
        end
    endgenerate
endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: default-parameter instance checked against a queue model every cycle, plus an FWFT instance.
module tb_fifo_param;
    localparam int DW = 32;
    localparam int DEPTH = 8;
    localparam int AF_T = 6;
    localparam int AE_T = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, en = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          empty, full, aempty, afull, ovf, udf;
    logic [3:0]    cnt;

    logic          f_rst = 1'b1, f_en = 1'b1, f_wr = 1'b0, f_rd = 1'b0;
    logic [DW-1:0] f_din = '0;
    logic [DW-1:0] f_dout;
    logic          f_empty, f_full, f_aempty, f_afull, f_ovf, f_udf;
    logic [3:0]    f_cnt;

    fifo_param u_dut (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .rd(rd), .dataIn(din),
        .dataOut(dout), .EMPTY(empty), .FULL(full), .ALMOST_EMPTY(aempty),
        .ALMOST_FULL(afull), .count(cnt), .OVERFLOW(ovf), .UNDERFLOW(udf)
    );

    fifo_param #(.FWFT(1)) u_fw (
        .clk(clk), .rst(f_rst), .en(f_en), .wr(f_wr), .rd(f_rd), .dataIn(f_din),
        .dataOut(f_dout), .EMPTY(f_empty), .FULL(f_full), .ALMOST_EMPTY(f_aempty),
        .ALMOST_FULL(f_afull), .count(f_cnt), .OVERFLOW(f_ovf), .UNDERFLOW(f_udf)
    );

    int total = 0;
    int bad = 0;

    // Scoreboard state
    logic [DW-1:0] sb_q[$];
    int            m_cnt = 0;
    logic [DW-1:0] m_dout = '0;
    logic          m_ovf = 1'b0, m_udf = 1'b0;

    typedef struct {
        logic          en, wr, rd;
        logic [DW-1:0] din;
        int            exp_cnt;
        logic [DW-1:0] exp_dout;
        logic          exp_ovf, exp_udf;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(input logic e, w, r, input logic [DW-1:0] d,
                                input int c, input logic [DW-1:0] o,
                                input logic ov, input logic un);
        vec_t v;
        v.en = e; v.wr = w; v.rd = r; v.din = d;
        v.exp_cnt = c; v.exp_dout = o; v.exp_ovf = ov; v.exp_udf = un;
        return v;
    endfunction

    task automatic chk(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".count"}, DW'(cnt), DW'(m_cnt));
        chk({tag, ".EMPTY"}, DW'(empty), DW'(m_cnt == 0));
        chk({tag, ".FULL"}, DW'(full), DW'(m_cnt == DEPTH));
        chk({tag, ".AEMPTY"}, DW'(aempty), DW'(m_cnt <= AE_T));
        chk({tag, ".AFULL"}, DW'(afull), DW'(m_cnt >= AF_T));
        chk({tag, ".OVF"}, DW'(ovf), DW'(m_ovf));
        chk({tag, ".UDF"}, DW'(udf), DW'(m_udf));
        chk({tag, ".dout"}, dout, m_dout);
    endtask

    // Called at a negedge: drive, advance the model, wait one edge, compare at the next negedge.
    task automatic cyc(input logic e, input logic w, input logic r, input logic [DW-1:0] d,
                       input string tag);
        logic m_pop, m_push;
        rst = 1'b0; en = e; wr = w; rd = r; din = d;
        m_pop  = e & r & (m_cnt > 0);
        m_push = e & w & ((m_cnt < DEPTH) | m_pop);
        m_ovf  = e & w & (m_cnt == DEPTH) & ~m_pop;
        m_udf  = e & r & (m_cnt == 0);
        if (m_pop) begin
            m_dout = sb_q.pop_front();
            m_cnt--;
        end
        if (m_push) begin
            sb_q.push_back(d);
            m_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
        chk_model(tag);
    endtask

    task automatic rst_cyc(input logic w, input logic r, input string tag);
        rst = 1'b1; en = 1'b1; wr = w; rd = r; din = 32'hDEAD_BEEF;
        sb_q.delete();
        m_cnt = 0; m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_model(tag);
    endtask

    initial begin
        logic [DW-1:0] held;
        @(negedge clk);

        for (int i = 0; i < 5; i++) rst_cyc(1'b1, 1'b1, "reset");

        // Basic order, underflow, fill/overflow, simultaneous at full, drain
        for (int i = 1; i <= 4; i++) vecs.push_back(mk(1, 1, 0, DW'(i), i, 0, 0, 0));
        for (int i = 1; i <= 4; i++) vecs.push_back(mk(1, 0, 1, 0, 4 - i, DW'(i), 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 4, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 4, 0, 0));
        for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 1, 0, DW'(32'h10 + i), i + 1, 4, 0, 0));
        vecs.push_back(mk(1, 1, 0, 32'hFF, 8, 4, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8, 4, 0, 0));
        vecs.push_back(mk(1, 1, 1, 32'hAA, 8, 32'h10, 0, 0));
        for (int i = 1; i < 8; i++) vecs.push_back(mk(1, 0, 1, 0, 8 - i, DW'(32'h10 + i), 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 32'hAA, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].en, vecs[i].wr, vecs[i].rd, vecs[i].din, $sformatf("v%0d", i));
            chk($sformatf("tbl%0d.count", i), DW'(cnt), DW'(vecs[i].exp_cnt));
            chk($sformatf("tbl%0d.dout", i), dout, vecs[i].exp_dout);
            chk($sformatf("tbl%0d.OVF", i), DW'(ovf), DW'(vecs[i].exp_ovf));
            chk($sformatf("tbl%0d.UDF", i), DW'(udf), DW'(vecs[i].exp_udf));
        end

        // Simultaneous rd/wr while empty: write wins, read underflows, no bypass
        cyc(1, 1, 1, 32'h77, "rw_empty");
        chk("rw_empty.count", DW'(cnt), 1);
        chk("rw_empty.UDF", DW'(udf), 1);
        cyc(1, 0, 1, 0, "rw_empty_drain");
        chk("rw_empty.word", dout, 32'h77);

        // 20 interleaved write/read pairs wrap both pointers
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 0, $urandom, "wrap_w");
            cyc(1, 0, 1, 0, "wrap_r");
        end

        // Enable low freezes everything
        cyc(1, 1, 0, 32'h1234, "frz_w0");
        cyc(1, 1, 0, 32'h5678, "frz_w1");
        cyc(1, 0, 1, 0, "frz_r");
        held = dout;
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 32'h9999, "frz");
        chk("frz.count", DW'(cnt), 1);
        chk("frz.dout", dout, held);
        chk("frz.dout_val", held, 32'h1234);

        // Reset mid-operation discards contents
        cyc(1, 1, 0, 32'h4242, "pre_rst");
        rst_cyc(1'b1, 1'b1, "mid_rst");
        cyc(1, 0, 1, 0, "post_rst_rd");
        chk("post_rst.UDF", DW'(udf), 1);

        // FWFT instance
        @(negedge clk);
        f_rst = 1'b0; f_wr = 1'b1; f_din = 32'h5;
        @(posedge clk); @(negedge clk);
        f_wr = 1'b0; f_din = '0;
        chk("fwft.dout", f_dout, 32'h5);
        chk("fwft.EMPTY", DW'(f_empty), 0);
        chk("fwft.count", DW'(f_cnt), 1);
        @(posedge clk); @(negedge clk);
        chk("fwft.hold", f_dout, 32'h5);
        f_rd = 1'b1;
        @(posedge clk); @(negedge clk);
        f_rd = 1'b0;
        chk("fwft.pop_EMPTY", DW'(f_empty), 1);
        chk("fwft.pop_count", DW'(f_cnt), 0);
        chk("fwft.pop_UDF", DW'(f_udf), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous FIFO; next generation of the 32-bit single-clock `fifo`.
- Generalises data width and depth.
- Adds programmable almost-full/almost-empty flags, an occupancy count, overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode.
- Drop-in buffer between producer/consumer stages on one clock domain.

Parameters:
- DATA_WIDTH, 32: width of dataIn/dataOut.
- DEPTH, 8: number of entries; power of two, >= 2.
- AFULL_THRESH, 6: ALMOST_FULL asserts when count >= AFULL_THRESH; must be 1..DEPTH.
- AEMPTY_THRESH, 2: ALMOST_EMPTY asserts when count <= AEMPTY_THRESH; must be 0..DEPTH-1.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset; priority over all other inputs.
- en  input  1  global enable; when 0, no push/pop, all state held.
- wr  input  1  write request.
- rd  input  1  read request.
- dataIn  input  DATA_WIDTH  write data.
- dataOut  output  DATA_WIDTH  read data.
- EMPTY  output  1  count == 0.
- FULL  output  1  count == DEPTH.
- ALMOST_EMPTY  output  1  count <= AEMPTY_THRESH.
- ALMOST_FULL  output  1  count >= AFULL_THRESH.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- OVERFLOW  output  1  one-cycle pulse: write rejected.
- UNDERFLOW  output  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (rst=1 at edge):
  - wr_ptr = rd_ptr = 0, count = 0, dataOut = 0.
  - EMPTY = 1, FULL = 0, ALMOST_EMPTY = 1, ALMOST_FULL = 0 (for AFULL_THRESH >= 1).
  - OVERFLOW = UNDERFLOW = 0.
  - Storage array not cleared.
  - Reset mid-operation discards all contents in that cycle regardless of en/wr/rd.
- en=0: pointers, count, dataOut and storage held; OVERFLOW/UNDERFLOW = 0.
- Define push = en & wr & (!FULL | rd_ok) and pop = en & rd & !EMPTY (rd_ok = pop).
  - Push writes dataIn to mem[wr_ptr]; wr_ptr increments modulo DEPTH.
  - Pop advances rd_ptr modulo DEPTH.
  - count += push - pop.
- Flags: EMPTY, FULL, ALMOST_* are combinational decodes of the registered count; they reflect the state after the edge, with no extra latency.
- Standard mode (FWFT=0):
  - On pop, dataOut <= mem[rd_ptr] at the same edge; data is valid the cycle after rd is sampled (1-cycle latency).
  - Without a pop, dataOut holds its last value.
- FWFT mode (FWFT=1):
  - dataOut = mem[rd_ptr] combinationally; head word is visible whenever EMPTY=0, and rd acknowledges and pops it.
  - dataOut is don't-care while EMPTY=1.
- Simultaneous rd & wr:
  - Not empty, not full: both occur; count unchanged.
  - FULL: pop frees a slot, so both occur; count stays DEPTH, no OVERFLOW.
  - EMPTY: write accepted; read rejected with UNDERFLOW pulse; count -> 1. No bypass: the new word is not returned that cycle.
- Errors:
  - wr while FULL without pop: write dropped, contents unchanged, OVERFLOW = 1 for the next cycle only.
  - rd while EMPTY: dataOut unchanged, UNDERFLOW = 1 for the next cycle only.
  - Both error pulses are registered and not sticky.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally; FULL/EMPTY come from count, never from pointer comparison.

Test Plan:
- Reset/defaults (defaults, FWFT=0):
  - Stimulus: rst=1 for 5 cycles with wr=rd=1.
  - Required: count=0, EMPTY=1, ALMOST_EMPTY=1, FULL=0, dataOut=0, no error pulses.
- Basic order:
  - Stimulus: en=1; write 1,2,3,4 on consecutive cycles, then rd=1 for 4 cycles.
  - Required: dataOut = 1,2,3,4, each one cycle after its rd edge; count 4->0; EMPTY=1 at end; ALMOST_FULL never set.
- Full/overflow:
  - Stimulus: write 0x10..0x17; then wr=1, dataIn=0xFF.
  - Required: FULL=1 and ALMOST_FULL=1 from count 6; OVERFLOW pulses once; subsequent reads return 0x10..0x17, never 0xFF.
- Simultaneous at full:
  - Stimulus: with FIFO full, rd=wr=1 and dataIn=0xAA for one cycle.
  - Required: count stays 8, no OVERFLOW; after draining, 0xAA is the last word out.
- Underflow and wrap:
  - Stimulus (a): empty FIFO, rd=1.
  - Required (a): UNDERFLOW one cycle, dataOut unchanged.
  - Stimulus (b): 20 interleaved write/read pairs (pointers wrap twice).
  - Required (b): data order preserved.
  - Stimulus (c): en=0 with wr=rd=1.
  - Required (c): count and dataOut frozen.
- FWFT=1:
  - Stimulus: write 0x5 into empty FIFO.
  - Required: dataOut=0x5 the cycle after the write, with rd=0.
  - Stimulus: rd=1.
  - Required: pops it; EMPTY=1 next cycle.
